uart_word_sender: RTL and testbench

- Transmit-side counterpart of the UART program-load path: serializes 32-bit result words from the core onto UART_TX.
- Each word is sent as four 8N1 bytes at a fixed baud.
- Words enter through a valid/ready handshake into a small FIFO, so the core can post a burst of results without stalling on every byte.
- Sits between CPU execution logic (output/print instructions) and the board TX pin.

---
 rtl/uart_word_sender.sv | 175 +++++++++++++++++
 tb/tb_uart_word_sender.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_sender.sv
// Buffers 32-bit result words in a small FIFO and sends each one as four
// big-endian 8N1 bytes on a registered, idle-high TX line.
module uart_word_sender #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] WORD_IN,
    input  logic        WORD_VALID,
    output logic        WORD_READY,
    output logic        UART_TX,
    output logic        BUSY
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          tx_q, tx_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    logic          push_s, pop_s, bit_done_s, fifo_empty_s;
    logic [7:0]    cur_byte_s;

    assign fifo_empty_s = (count_q == {(PW + 1){1'b0}});
    // Readiness looks only at the stored count, so a same-cycle pop never frees a full FIFO.
    assign WORD_READY   = (count_q != FULL_CNT);
    assign push_s       = WORD_VALID && WORD_READY;
    assign bit_done_s   = (clk_cnt_q == CNT_MAX);
    assign cur_byte_s   = shreg_q[31:24];
    assign UART_TX      = tx_q;
    assign BUSY         = (state_q != S_IDLE) || !fifo_empty_s;

    // Frame sequencer: next state, bit timing and next TX level.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        pop_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = {CW{1'b0}};
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shreg_d    = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            S_START: begin
                if (bit_done_s) begin
                    clk_cnt_d = {CW{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    tx_d      = cur_byte_s[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_done_s) begin
                    clk_cnt_d = {CW{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte_s[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_done_s) begin
                    clk_cnt_d = {CW{1'b0}};
                    bit_idx_d = 3'd0;
                    // Next byte or next word follows the stop bit with no idle gap.
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shreg_d    = {shreg_q[23:0], 8'h00};
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        shreg_d    = mem_q[rd_ptr_q];
                        byte_idx_d = 2'd0;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = {CW{1'b0}};
                tx_d      = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset drops any partially sent word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= {CW{1'b0}};
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            shreg_q    <= 32'h0000_0000;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= WORD_IN;
        end
    end
endmodule

// File: tb/tb_uart_word_sender.sv
// Scoreboard bench: pushes expected bytes on each accepted word; an 8N1 line
// decoder pops and compares every received frame.
module tb_uart_word_sender;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word_in;
    logic        valid;
    logic        sel;
    logic        tx4, ready4, busy4, tx5, ready5, busy5;
    logic        tx_m, ready_m, busy_m;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rx_bytes   = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_word_sender #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
        .CLK(clk), .RESET(rst), .WORD_IN(word_in), .WORD_VALID(valid & ~sel),
        .WORD_READY(ready4), .UART_TX(tx4), .BUSY(busy4));
    uart_word_sender #(.CLKS_PER_BIT(5), .FIFO_DEPTH(4)) u_dut5 (
        .CLK(clk), .RESET(rst), .WORD_IN(word_in), .WORD_VALID(valid & sel),
        .WORD_READY(ready5), .UART_TX(tx5), .BUSY(busy5));

    assign tx_m    = sel ? tx5 : tx4;
    assign ready_m = sel ? ready5 : ready4;
    assign busy_m  = sel ? busy5 : busy4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns the cycle number of the edge that accepted the word.
    task automatic push_word(input logic [31:0] w, output int pc);
        int guard = 0;
        word_in = w;
        valid   = 1'b1;
        while (!ready_m && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_m) chk("push_timeout", 32'd0, 32'd1);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        @(negedge clk);
        pc    = cyc;
        valid = 1'b0;
    endtask

    task automatic wait_busy_low(input int budget, output int fall);
        int n = 0;
        while (busy_m && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_m) chk("busy_timeout", 32'd1, 32'd0);
        fall = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Line decoder: every cycle of a bit window must hold the same level.
    logic       frame_ok, abort_f, lvl;
    logic [7:0] rx_data;
    int         cpb_m;
    always begin
        @(negedge clk);
        if (!rst && tx_m == 1'b0) begin
            frame_ok = 1'b1;
            abort_f  = 1'b0;
            lvl      = 1'b0;
            rx_data  = 8'h00;
            cpb_m    = sel ? 5 : 4;
            starts.push_back(cyc);
            for (int b = 0; b < 10 && !abort_f; b++) begin
                for (int c = 0; c < cpb_m && !abort_f; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst) abort_f = 1'b1;
                    else if (c == 0) lvl = tx_m;
                    else if (tx_m != lvl) frame_ok = 1'b0;
                end
                if (!abort_f) begin
                    if (b == 0 && lvl != 1'b0) frame_ok = 1'b0;
                    if (b >= 1 && b <= 8) rx_data[b-1] = lvl;
                    if (b == 9 && lvl != 1'b1) frame_ok = 1'b0;
                end
            end
            if (!abort_f) begin
                chk("rx_framing", {31'd0, frame_ok}, 32'd1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rx_unexpected: got byte 0x%02h, no byte expected", rx_data);
                end else begin
                    chk("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
                rx_bytes++;
            end
        end
    end

    logic [31:0] t3_words [6] = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303,
                                  32'h0404_0404, 32'h0505_0505, 32'h0606_0606};
    logic [31:0] t5_words [20] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001,
                                   32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0, 32'h5555_AAAA,
                                   32'hC001_D00D, 32'h7E57_0042, 32'h0123_4567, 32'h89AB_CDEF,
                                   32'hFEDC_BA98, 32'h7654_3210, 32'h00FF_00FF, 32'hA5A5_5A5A,
                                   32'h1111_2222, 32'h3333_4444, 32'hCAFE_F00D, 32'h8BAD_F00D};

    initial begin
        int pc, p1, p2, p5, p6, pa, pb, pc3, fall, s, lows, rx0;
        rst     = 1'b1;
        valid   = 1'b0;
        word_in = 32'h0;
        sel     = 1'b0;
        #2;
        chk("rst_tx", {31'd0, tx_m}, 32'd1);
        chk("rst_ready", {31'd0, ready_m}, 32'd1);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word: latency, bit timing, BUSY length.
        starts.delete();
        push_word(32'h1234_5678, pc);
        chk("t1_tx_still_idle", {31'd0, tx_m}, 32'd1);
        @(negedge clk);
        chk("t1_tx_fall", {31'd0, tx_m}, 32'd0);
        wait_busy_low(400, fall);
        chk("t1_busy_len", 32'(fall - (pc + 1)), 32'd160);
        wait_drain(50);
        chk("t1_first_start", 32'(starts[0]), 32'(pc + 1));

        // Two words back to back: eight contiguous frames.
        repeat (5) @(negedge clk);
        starts.delete();
        push_word(32'h0000_00FF, p1);
        push_word(32'hA5A5_A5A5, p2);
        chk("t2_back_to_back", 32'(p2 - p1), 32'd1);
        wait_busy_low(800, fall);
        chk("t2_total_len", 32'(fall - (p1 + 1)), 32'd320);
        wait_drain(50);
        chk("t2_frames", 32'(starts.size()), 32'd8);
        for (int i = 1; i < 8 && i < starts.size(); i++)
            chk("t2_frame_gap", 32'(starts[i] - starts[i-1]), 32'd40);

        // FIFO fill with WORD_VALID held: word 6 waits for the first word to finish.
        repeat (5) @(negedge clk);
        rx0 = rx_bytes;
        push_word(t3_words[0], p1);
        for (int i = 1; i < 5; i++) push_word(t3_words[i], p5);
        chk("t3_five_accepted", 32'(p5 - p1), 32'd4);
        chk("t3_ready_full", {31'd0, ready_m}, 32'd0);
        push_word(t3_words[5], p6);
        chk("t3_word6_accept", 32'(p6 - p1), 32'd162);
        wait_busy_low(2000, fall);
        wait_drain(50);
        chk("t3_byte_count", 32'(rx_bytes - rx0), 32'd24);

        // Reset during data bit 3 of byte 2 with two words queued.
        repeat (5) @(negedge clk);
        push_word(32'h1122_3344, pa);
        push_word(32'hCCCC_CCCC, pb);
        push_word(32'h3333_3333, pc3);
        s = pa + 1;
        while (cyc < s + 57) @(negedge clk);
        chk("t4_pre_tx", {31'd0, tx_m}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t4_rst_tx", {31'd0, tx_m}, 32'd1);
        chk("t4_rst_busy", {31'd0, busy_m}, 32'd0);
        chk("t4_rst_ready", {31'd0, ready_m}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_m == 1'b0) lows++;
        end
        chk("t4_line_quiet", 32'(lows), 32'd0);
        chk("t4_busy_quiet", {31'd0, busy_m}, 32'd0);
        starts.delete();
        push_word(32'h0000_0001, pc);
        @(negedge clk);
        chk("t4_fresh_start", {31'd0, tx_m}, 32'd0);
        wait_busy_low(400, fall);
        chk("t4_busy_len", 32'(fall - (pc + 1)), 32'd160);
        wait_drain(50);

        // Stream of 20 words with random gaps on the 5-clock-per-bit instance.
        repeat (5) @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        rx0 = rx_bytes;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            push_word(t5_words[i], pc);
        end
        wait_busy_low(6000, fall);
        wait_drain(100);
        chk("t5_byte_count", 32'(rx_bytes - rx0), 32'd80);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
